// File: rtl/map_write_arbiter_if.sv
// Shared definitions for the map write arbiter: tile code encoding and the
// VGA timing stream bundle.
// Ports (vga_if.in): hcount, vcount, hsync, vsync, hblnk, vblnk, all inputs.
package snake_pkg;
  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] WALL   = 3'd1;
  localparam logic [2:0] SNAKE1 = 3'd2;
  localparam logic [2:0] SNAKE2 = 3'd3;
  localparam logic [2:0] POINT  = 3'd4;
endpackage

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/map_write_arbiter.sv
// Purpose: round-robin arbiter giving three requesters read-check-write access to the tile map.
// Latency: ack/map_we 2 cycles after the grant cycle; at most one write every 3 cycles.
// Backpressure: requesters hold req until ack; losers simply wait for a later IDLE slot.
// Ports: clk, rst (sync, active high); vga_in (vblnk only); req/req_row/req_col/req_tile
//   per requester (0 snake1, 1 snake2, 2 point gen); rd_tile from map storage;
//   map_we/map_row/map_col/map_wdata map write port; ack, collision, busy status.
// Build option: define MAP_ARB_VBLNK_GATE_EN to allow new grants only while vga_in.vblnk=1.
module map_write_arbiter #(
  parameter int ROW_B  = 5,
  parameter int COL_B  = 6,
  parameter int TILE_B = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.in                      vga_in,
  input  logic [2:0]             req,
  input  logic [2:0][ROW_B-1:0]  req_row,
  input  logic [2:0][COL_B-1:0]  req_col,
  input  logic [2:0][TILE_B-1:0] req_tile,
  input  logic [TILE_B-1:0]      rd_tile,
  output logic                   map_we,
  output logic [ROW_B-1:0]       map_row,
  output logic [COL_B-1:0]       map_col,
  output logic [TILE_B-1:0]      map_wdata,
  output logic [2:0]             ack,
  output logic [2:0]             collision,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic [ROW_B-1:0]  row_q, row_d;
  logic [COL_B-1:0]  col_q, col_d;
  logic [TILE_B-1:0] tile_q, tile_d;
  logic [TILE_B-1:0] rd_q, rd_d;

  logic       win_open;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand1, cand2;
  logic       in_write;
  logic       rd_hit;
  logic [2:0] win_onehot;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

`ifdef MAP_ARB_VBLNK_GATE_EN
  assign win_open = vga_in.vblnk;
`else
  assign win_open = 1'b1;
`endif

  // Search order starts at ptr and wraps modulo 3.
  assign cand1 = inc3(ptr_q);
  assign cand2 = inc3(cand1);

  always_comb begin
    grant_vld = 1'b1;
    grant_idx = ptr_q;
    if (req[ptr_q])      grant_idx = ptr_q;
    else if (req[cand1]) grant_idx = cand1;
    else if (req[cand2]) grant_idx = cand2;
    else                 grant_vld = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    row_d   = row_q;
    col_d   = col_q;
    tile_d  = tile_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_open && grant_vld) begin
          win_d   = grant_idx;
          row_d   = req_row[grant_idx];
          col_d   = req_col[grant_idx];
          tile_d  = req_tile[grant_idx];
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Address is already on map_row/map_col; capture what sits there now.
        rd_d    = rd_tile;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ptr_d   = inc3(win_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
      tile_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      rd_q    <= rd_d;
    end
  end

  // Gating with rst kills a pending write in the very cycle reset is raised.
  assign in_write   = (state_q == S_WRITE) && !rst;
  assign win_onehot = 3'b001 << win_q;
  assign rd_hit     = (rd_q != TILE_B'(snake_pkg::EMPTY)) &&
                      (rd_q != TILE_B'(snake_pkg::POINT));

  assign map_we     = in_write;
  assign map_row    = row_q;
  assign map_col    = col_q;
  assign map_wdata  = tile_q;
  assign ack        = in_write ? win_onehot : 3'b000;
  // The point generator never reports a collision.
  assign collision  = (in_write && (win_q != 2'd2) && rd_hit) ? win_onehot : 3'b000;
  assign busy       = (state_q != S_IDLE) && !rst;

endmodule

// File: tb/tb_map_write_arbiter.sv
module tb_map_write_arbiter;
  localparam int ROW_B  = 5;
  localparam int COL_B  = 6;
  localparam int TILE_B = 3;

  localparam logic [2:0] T_EMPTY  = 3'd0;
  localparam logic [2:0] T_WALL   = 3'd1;
  localparam logic [2:0] T_SNAKE1 = 3'd2;
  localparam logic [2:0] T_SNAKE2 = 3'd3;
  localparam logic [2:0] T_POINT  = 3'd4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2:0]             req;
  logic [2:0][ROW_B-1:0]  req_row;
  logic [2:0][COL_B-1:0]  req_col;
  logic [2:0][TILE_B-1:0] req_tile;
  logic [TILE_B-1:0]      rd_tile;
  logic                   map_we;
  logic [ROW_B-1:0]       map_row;
  logic [COL_B-1:0]       map_col;
  logic [TILE_B-1:0]      map_wdata;
  logic [2:0]             ack;
  logic [2:0]             collision;
  logic                   busy;

  vga_if vga_bus ();

  logic [TILE_B-1:0] tbmap [32][64];
  assign rd_tile = tbmap[map_row][map_col];

  map_write_arbiter #(.ROW_B(ROW_B), .COL_B(COL_B), .TILE_B(TILE_B)) dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vga_bus),
    .req       (req),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_tile  (req_tile),
    .rd_tile   (rd_tile),
    .map_we    (map_we),
    .map_row   (map_row),
    .map_col   (map_col),
    .map_wdata (map_wdata),
    .ack       (ack),
    .collision (collision),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] row;
    logic [5:0] col;
    logic [2:0] tile;
    logic [2:0] ack;
    logic [2:0] coll;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_exp(input int at, input logic [4:0] r, input logic [5:0] c,
                          input logic [2:0] t, input logic [2:0] a, input logic [2:0] co);
    exp_t e;
    e.cyc = at; e.row = r; e.col = c; e.tile = t; e.ack = a; e.coll = co;
    sbq.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, check against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("wr_we",    32'(map_we),    32'd1);
      chk("wr_row",   32'(map_row),   32'(e.row));
      chk("wr_col",   32'(map_col),   32'(e.col));
      chk("wr_data",  32'(map_wdata), 32'(e.tile));
      chk("wr_ack",   32'(ack),       32'(e.ack));
      chk("wr_coll",  32'(collision), 32'(e.coll));
      chk("wr_busy",  32'(busy),      32'd1);
    end else if (sbq.size() > 0 && sbq[0].cyc == cyc + 1) begin
      chk("rd_we",    32'(map_we),    32'd0);
      chk("rd_ack",   32'(ack),       32'd0);
      chk("rd_busy",  32'(busy),      32'd1);
      chk("rd_row",   32'(map_row),   32'(sbq[0].row));
      chk("rd_col",   32'(map_col),   32'(sbq[0].col));
    end else begin
      chk("nowr_we",   32'(map_we),    32'd0);
      chk("nowr_ack",  32'(ack),       32'd0);
      chk("nowr_coll", 32'(collision), 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [5:0] c, input logic [2:0] t);
    req_row[i]  = r;
    req_col[i]  = c;
    req_tile[i] = t;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   32'(map_we),    32'd0);
    chk({tag, "_row"},  32'(map_row),   32'd0);
    chk({tag, "_col"},  32'(map_col),   32'd0);
    chk({tag, "_data"}, 32'(map_wdata), 32'd0);
    chk({tag, "_ack"},  32'(ack),       32'd0);
    chk({tag, "_coll"}, 32'(collision), 32'd0);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        tbmap[r][c] = T_EMPTY;
    rst = 1'b1;
    req = 3'b000;
    req_row = '0;
    req_col = '0;
    req_tile = '0;
    vga_bus.vblnk = 1'b0;

    // Reset state
    ticks(2);
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // Write window: vblnk low, single snake1 request
    set_req(0, 5'd4, 6'd7, T_SNAKE1);
    tbmap[4][7] = T_EMPTY;
    req = 3'b001;
`ifdef MAP_ARB_VBLNK_GATE_EN
    ticks(3);
    chk("gate_busy", 32'(busy), 32'd0);
    vga_bus.vblnk = 1'b1;
`endif
    push_exp(cyc + 2, 5'd4, 6'd7, T_SNAKE1, 3'b001, 3'b000);
    tick();
    req = 3'b000;
    ticks(3);
    vga_bus.vblnk = 1'b1;
    // Address/data hold after the transaction
    chk("hold_row",  32'(map_row),   32'd4);
    chk("hold_col",  32'(map_col),   32'd7);
    chk("hold_data", 32'(map_wdata), 32'(T_SNAKE1));
    chk("hold_busy", 32'(busy),      32'd0);

    // Snake1 onto WALL -> collision
    tbmap[4][7] = T_WALL;
    req = 3'b001;
    push_exp(cyc + 2, 5'd4, 6'd7, T_SNAKE1, 3'b001, 3'b001);
    tick();
    req = 3'b000;
    ticks(3);

    // Snake1 onto POINT -> no collision
    tbmap[4][7] = T_POINT;
    req = 3'b001;
    push_exp(cyc + 2, 5'd4, 6'd7, T_SNAKE1, 3'b001, 3'b000);
    tick();
    req = 3'b000;
    ticks(3);

    // ptr=1, req=101: order 1,2,0 -> point generator wins, never collides
    set_req(2, 5'd10, 6'd20, T_POINT);
    tbmap[10][20] = T_SNAKE2;
    req = 3'b101;
    push_exp(cyc + 2, 5'd10, 6'd20, T_POINT, 3'b100, 3'b000);
    tick();
    req = 3'b000;
    ticks(3);

    // ptr=0: snake2 onto SNAKE1 at the max address -> collision[1]
    set_req(1, 5'd31, 6'd63, T_SNAKE2);
    tbmap[31][63] = T_SNAKE1;
    req = 3'b010;
    push_exp(cyc + 2, 5'd31, 6'd63, T_SNAKE2, 3'b010, 3'b010);
    tick();
    req = 3'b000;
    ticks(3);

    // Atomicity: vblnk falls and req drops during READ
    set_req(0, 5'd2, 6'd3, T_SNAKE1);
    tbmap[2][3] = T_EMPTY;
    req = 3'b001;
    push_exp(cyc + 2, 5'd2, 6'd3, T_SNAKE1, 3'b001, 3'b000);
    tick();
    vga_bus.vblnk = 1'b0;
    req = 3'b000;
    ticks(3);
    vga_bus.vblnk = 1'b1;

    // Reset during READ: no write, no ack, outputs cleared, ptr back to 0
    set_req(0, 5'd5, 6'd5, T_SNAKE1);
    req = 3'b001;
    tick();
    chk("abort_busy_rd", 32'(busy), 32'd1);
    rst = 1'b1;
    req = 3'b000;
    #1;
    chk("abort_we_now",  32'(map_we), 32'd0);
    chk("abort_ack_now", 32'(ack),    32'd0);
    tick();
    chk_all_zero("abort");
    rst = 1'b0;
    ticks(3);

    // req=111 held from ptr=0: acks 001,010,100,001 three cycles apart
    set_req(0, 5'd1, 6'd1, T_SNAKE1);
    set_req(1, 5'd1, 6'd2, T_SNAKE2);
    set_req(2, 5'd1, 6'd3, T_POINT);
    tbmap[1][1] = T_EMPTY;
    tbmap[1][2] = T_EMPTY;
    tbmap[1][3] = T_EMPTY;
    req = 3'b111;
    push_exp(cyc + 2,  5'd1, 6'd1, T_SNAKE1, 3'b001, 3'b000);
    push_exp(cyc + 5,  5'd1, 6'd2, T_SNAKE2, 3'b010, 3'b000);
    push_exp(cyc + 8,  5'd1, 6'd3, T_POINT,  3'b100, 3'b000);
    push_exp(cyc + 11, 5'd1, 6'd1, T_SNAKE1, 3'b001, 3'b000);
    ticks(10);
    req = 3'b000;
    ticks(3);

    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
